// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the synchronous imem and loads IF/ID.
// Handles hazard stalls and redirects, and counts fetches and flushes.
module fetch_stage #(
    parameter int PC_WIDTH = 12,
    parameter int INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  ifid_valid,
    output logic [PC_WIDTH-1:0]   ifid_pc,
    output logic [PC_WIDTH-1:0]   ifid_pc_plus1,
    output logic [INST_WIDTH-1:0] ifid_inst,
    output logic [4:0]            ifid_opcode,
    output logic [31:0]           fetch_count,
    output logic [31:0]           flush_count
);

    typedef enum logic {BOOT, RUN} state_t;

    typedef struct packed {
        logic                  valid;
        logic [PC_WIDTH-1:0]   pc;
        logic [PC_WIDTH-1:0]   pc_plus1;
        logic [INST_WIDTH-1:0] inst;
    } ifid_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                req_valid_q, req_valid_d;
    ifid_t               ifid_q, ifid_d;
    logic [31:0]         fetch_q, fetch_d;
    logic [31:0]         flush_q, flush_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        ifid_d      = ifid_q;
        fetch_d     = fetch_q;
        flush_d     = flush_q;
        imem_addr   = pc_q;
        if (reset) begin
            imem_addr = RESET_PC;
        end else if (redirect_valid) begin
            // Squash the wrong-path word even under stall
            imem_addr    = redirect_pc;
            pc_d         = redirect_pc + PC_ONE;
            req_pc_d     = redirect_pc;
            req_valid_d  = 1'b1;
            ifid_d.valid = 1'b0;
            flush_d      = flush_q + 32'd1;
            state_d      = RUN;
        end else if (state_q == BOOT) begin
            req_pc_d     = pc_q;
            req_valid_d  = 1'b1;
            pc_d         = pc_q + PC_ONE;
            ifid_d.valid = 1'b0;
            state_d      = RUN;
        end else if (stall) begin
            // Re-read the in-flight word so it is still on imem_rdata later
            imem_addr = req_pc_q;
        end else begin
            ifid_d.inst     = imem_rdata;
            ifid_d.pc       = req_pc_q;
            ifid_d.pc_plus1 = req_pc_q + PC_ONE;
            ifid_d.valid    = req_valid_q;
            req_pc_d        = pc_q;
            req_valid_d     = 1'b1;
            pc_d            = pc_q + PC_ONE;
            if (req_valid_q) begin
                fetch_d = fetch_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
            ifid_q      <= '0;
            fetch_q     <= '0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            ifid_q      <= ifid_d;
            fetch_q     <= fetch_d;
            flush_q     <= flush_d;
        end
    end

    assign ifid_valid    = ifid_q.valid;
    assign ifid_pc       = ifid_q.pc;
    assign ifid_pc_plus1 = ifid_q.pc_plus1;
    assign ifid_inst     = ifid_q.inst;
    assign ifid_opcode   = ifid_q.valid ? ifid_q.inst[INST_WIDTH-1 -: 5] : 5'd0;
    assign fetch_count   = fetch_q;
    assign flush_count   = flush_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table plus an in-order
// scoreboard of delivered instructions.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        ifid_valid;
    logic [11:0] ifid_pc;
    logic [11:0] ifid_pc_plus1;
    logic [31:0] ifid_inst;
    logic [4:0]  ifid_opcode;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.PC_WIDTH(12), .INST_WIDTH(32), .RESET_PC(12'h000)) dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid),
        .ifid_pc(ifid_pc),
        .ifid_pc_plus1(ifid_pc_plus1),
        .ifid_inst(ifid_inst),
        .ifid_opcode(ifid_opcode),
        .fetch_count(fetch_count),
        .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {a[4:0], 15'd0, a};
    endfunction

    always @(posedge clock) imem_rdata <= mem_word(imem_addr);

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rv;
        logic [11:0] rpc;
        logic [11:0] exp_addr;
        logic        exp_valid;
        logic [11:0] exp_pc;
        int          exp_fetch;
        int          exp_flush;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] sb[$];

    function automatic vec_t mk(logic r, logic s, logic v, logic [11:0] rp,
                                logic [11:0] a, logic ev, logic [11:0] ep,
                                int ef, int efl);
        vec_t x;
        x.rst = r; x.stl = s; x.rv = v; x.rpc = rp;
        x.exp_addr = a; x.exp_valid = ev; x.exp_pc = ep;
        x.exp_fetch = ef; x.exp_flush = efl;
        return x;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t        v;
        logic [11:0] e;
        logic [11:0] p1;
        logic [31:0] w;

        // rst stl rv rpc | addr valid pc fetch flush
        vecs.push_back(mk(1, 0, 0, 12'h000, 12'h000, 0, 12'h000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 12'h000, 12'h000, 0, 12'h000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 12'h000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h001, 1, 12'h000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h002, 1, 12'h001, 2, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h003, 1, 12'h002, 3, 0));
        vecs.push_back(mk(0, 1, 0, 12'h000, 12'h003, 1, 12'h002, 3, 0));
        vecs.push_back(mk(0, 1, 0, 12'h000, 12'h003, 1, 12'h002, 3, 0));
        vecs.push_back(mk(0, 1, 0, 12'h000, 12'h003, 1, 12'h002, 3, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h004, 1, 12'h003, 4, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h005, 1, 12'h004, 5, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h006, 1, 12'h005, 6, 0));
        vecs.push_back(mk(0, 0, 1, 12'h040, 12'h040, 0, 12'h000, 6, 1));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h041, 1, 12'h040, 7, 1));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h042, 1, 12'h041, 8, 1));
        vecs.push_back(mk(0, 1, 1, 12'h080, 12'h080, 0, 12'h000, 8, 2));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h081, 1, 12'h080, 9, 2));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h082, 1, 12'h081, 10, 2));
        vecs.push_back(mk(0, 0, 1, 12'h100, 12'h100, 0, 12'h000, 10, 3));
        vecs.push_back(mk(0, 0, 1, 12'hFFF, 12'hFFF, 0, 12'h000, 10, 4));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h000, 1, 12'hFFF, 11, 4));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h001, 1, 12'h000, 12, 4));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h002, 1, 12'h001, 13, 4));
        vecs.push_back(mk(0, 1, 0, 12'h000, 12'h002, 1, 12'h001, 13, 4));
        vecs.push_back(mk(1, 1, 1, 12'h055, 12'h000, 0, 12'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 12'h000, 12'h000, 0, 12'h000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h001, 1, 12'h000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 12'h002, 1, 12'h001, 2, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            reset          = v.rst;
            stall          = v.stl;
            redirect_valid = v.rv;
            redirect_pc    = v.rpc;
            if (v.exp_valid && !v.stl && !v.rst) sb.push_back(v.exp_pc);
            #1;
            chk($sformatf("imem_addr[%0d]", i), imem_addr, v.exp_addr);
            @(posedge clock);
            #1;
            chk($sformatf("ifid_valid[%0d]", i), ifid_valid, v.exp_valid);
            chk($sformatf("fetch_count[%0d]", i), fetch_count, v.exp_fetch);
            chk($sformatf("flush_count[%0d]", i), flush_count, v.exp_flush);
            if (v.exp_valid || v.rst)
                chk($sformatf("ifid_pc[%0d]", i), ifid_pc, v.exp_pc);
            if (!v.exp_valid)
                chk($sformatf("opcode_zero[%0d]", i), ifid_opcode, 0);
            if (ifid_valid && !v.stl) begin
                if (sb.size() == 0) begin
                    chk($sformatf("sb_underflow[%0d]", i), 1, 0);
                end else begin
                    e  = sb.pop_front();
                    p1 = e + 12'd1;
                    w  = mem_word(e);
                    chk($sformatf("sb_pc[%0d]", i), ifid_pc, e);
                    chk($sformatf("sb_inst[%0d]", i), ifid_inst, w);
                    chk($sformatf("sb_opcode[%0d]", i), ifid_opcode, e[4:0]);
                    chk($sformatf("sb_pc_plus1[%0d]", i), ifid_pc_plus1, p1);
                end
            end
        end
        chk("sb_leftover", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
